// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: shares one sram-like bridge port
// between the fetch (inst) and memory (data) requesters.
module cpu_sram_arbiter #(
  parameter bit DATA_PRIO = 1'b1,
  parameter bit RR_INIT   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        owner;
  logic        last_owner;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic idle;
  logic grant_data;
  logic grant_inst;
  logic resp_done;

  // Winner select: data wins a tie under fixed priority,
  // otherwise the side that was not granted last time.
  always_comb begin
    idle       = (state == IDLE);
    grant_data = data_req &
                 (~inst_req | DATA_PRIO | ~last_owner);
    grant_inst = inst_req & ~grant_data;
    resp_done  = (state == RESP) & mem_data_ok;
  end

  // Handshake outputs are masked while reset is held so
  // nothing leaks out before the state register clears.
  always_comb begin
    inst_addr_ok = ~reset & idle & grant_inst;
    data_addr_ok = ~reset & idle & grant_data;
    inst_data_ok = ~reset & resp_done & ~owner;
    data_data_ok = ~reset & resp_done & owner;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    mem_req      = ~reset & (state == REQ);
    mem_wr       = lat_wr;
    mem_size     = lat_size;
    mem_addr     = lat_addr;
    mem_wdata    = lat_wdata;
  end

  // Transaction FSM: latch the winner's payload, hold it
  // until the bridge accepts, then wait for its response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= RR_INIT;
      lat_wr     <= 1'b0;
      lat_size   <= 2'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_data) begin
            state      <= REQ;
            owner      <= 1'b1;
            last_owner <= 1'b1;
            lat_wr     <= data_wr;
            lat_size   <= data_size;
            lat_addr   <= data_addr;
            lat_wdata  <= data_wdata;
          end else if (grant_inst) begin
            state      <= REQ;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            lat_wr     <= 1'b0;
            lat_size   <= 2'd2;
            lat_addr   <= inst_addr;
            lat_wdata  <= 32'd0;
          end
        end
        REQ: begin
          if (mem_addr_ok) state <= RESP;
        end
        RESP: begin
          if (mem_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
Shares one sram-like memory port between the fetch stage (read-only instruction requester) and the memory stage (read/write data requester). Sits between the pipeline and the single memory bridge. Accepts at most one transaction at a time and routes the response back to its owner. Priority is fixed (data over instruction) or round-robin, selected by parameter.

Parameters:
DATA_PRIO, 1, 1 = data requester always wins a simultaneous request; 0 = round-robin, alternating on the last granted owner.
RR_INIT, 0, initial "last owner" for round-robin after reset (0 = inst, so data wins the first tie).

Ports:
clk           in   1   clock
reset         in   1   synchronous active-high reset
inst_req      in   1   instruction read request
inst_addr     in   32  instruction address
inst_addr_ok  out  1   instruction request accepted this cycle
inst_rdata    out  32  instruction read data
inst_data_ok  out  1   instruction response valid this cycle
data_req      in   1   data request
data_wr       in   1   1 = write, 0 = read
data_size     in   2   0 = byte, 1 = half, 2 = word
data_addr     in   32  data address
data_wdata    in   32  write data
data_addr_ok  out  1   data request accepted this cycle
data_rdata    out  32  data read data
data_data_ok  out  1   data response valid this cycle (reads and writes)
mem_req       out  1   request to memory bridge
mem_wr        out  1   write flag to bridge
mem_size      out  2   size to bridge
mem_addr      out  32  address to bridge
mem_wdata     out  32  write data to bridge
mem_addr_ok   in   1   bridge accepted request
mem_rdata     in   32  bridge read data
mem_data_ok   in   1   bridge response valid

Behaviour:
- Reset is synchronous, active-high, on clk. During and after reset: state=IDLE, last_owner=RR_INIT. All *_addr_ok, *_data_ok and mem_req are 0. mem_* payload registers are 0.
- FSM states: IDLE, REQ, RESP. Registers: owner (0 = inst, 1 = data), and a latched wr/size/addr/wdata.
- IDLE:
  - If no request, stay in IDLE.
  - If one request is present, grant it.
  - If both are present: with DATA_PRIO=1, grant data. With DATA_PRIO=0, grant the requester that is not last_owner.
  - On grant, assert the winner's *_addr_ok combinationally in the same cycle (the loser sees 0), latch the payload and owner, set last_owner=winner, and go to REQ.
  - For inst grants, the latched values are wr=0, size=2, wdata=0.
- REQ:
  - mem_req=1; mem_* are driven from latched registers, held stable.
  - When mem_addr_ok=1, go to RESP. Otherwise stay.
  - No *_addr_ok is asserted in REQ or RESP; new requests wait.
- RESP:
  - mem_req=0.
  - When mem_data_ok=1, drive owner's *_data_ok=1 and *_rdata=mem_rdata combinationally in that cycle, then go to IDLE.
  - Writes also complete via mem_data_ok.
- Minimum turnaround: accept in cycle N, mem_req in cycle N+1. If mem_addr_ok arrives in N+1 and mem_data_ok in N+2, *_data_ok is in N+2 and the next accept is possible in N+3.
- Spurious responses: mem_data_ok in IDLE or REQ is ignored and produces no *_data_ok. mem_addr_ok in IDLE or RESP is ignored.
- The non-owner's *_data_ok is always 0. Both *_rdata outputs may mirror mem_rdata at all times; only *_data_ok qualifies them.
- Reset mid-transaction returns to IDLE and drops the outstanding response. A late mem_data_ok after reset is ignored per the rule above.
- Requester inputs are sampled only in IDLE. A requester that drops its request before being accepted is not served.

Test Plan:
- Single inst read: inst_req=1, addr=0xbfc00000. Bridge gives addr_ok in cycle 1 and data_ok with rdata=0x24010001 in cycle 3. Expect inst_addr_ok in cycle 0, mem_req=1 with mem_addr=0xbfc00000 and mem_wr=0 in cycle 1, inst_data_ok=1 with inst_rdata=0x24010001 in cycle 3, and data_data_ok=0 throughout.
- Tie with DATA_PRIO=1: inst_req and data_req (write, size=2, addr=0x1000, wdata=0xdeadbeef) asserted together. Expect data_addr_ok=1 and inst_addr_ok=0. mem_wr=1, mem_wdata=0xdeadbeef. After data_data_ok, the inst request is accepted in the next IDLE cycle.
- Tie with DATA_PRIO=0, RR_INIT=0: both requesters hold requests continuously. Expect grants in the order data, inst, data, inst across four transactions.
- Bridge stall: mem_addr_ok held low for 5 cycles. Expect mem_req=1 and mem_addr/mem_wdata/mem_size constant for all 5 cycles. No *_addr_ok is asserted while requests remain high.
- Spurious mem_data_ok in IDLE and in REQ: expect no *_data_ok and no state change.
- Reset asserted in RESP, with mem_data_ok arriving the cycle after reset deasserts: expect IDLE, mem_req=0, no *_data_ok. The next inst_req is accepted normally.
